// File: rtl/mul.sv
// Iterative 32-cycle shift-add multiplier producing a 64-bit {hi,lo} product.
// Signed (MULT) support is compiled in only when MUL_SIGNED_EN is defined.
module mul #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             instr,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]    mcand_q, mcand_d;
    logic [2*WIDTH:0]    prod_q, prod_d;
    logic [WIDTH-1:0]    lo_q, lo_d;
    logic [WIDTH-1:0]    hi_q, hi_d;
    logic                done_q, done_d;

    logic [WIDTH-1:0]    mag_a, mag_b;
    logic [WIDTH:0]      sum;
    logic [2*WIDTH:0]    step;
    logic [2*WIDTH-1:0]  res;

`ifdef MUL_SIGNED_EN
    logic neg_q, neg_d;
`else
    logic unused_instr;
    assign unused_instr = instr;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        done_d  = 1'b0;
`ifdef MUL_SIGNED_EN
        neg_d   = neg_q;
        // Magnitudes stay exact for 0x80000000: -(2^31) reinterpreted unsigned is 2^31.
        mag_a   = (instr && a[WIDTH-1]) ? -a : a;
        mag_b   = (instr && b[WIDTH-1]) ? -b : b;
`else
        mag_a   = a;
        mag_b   = b;
`endif

        // Upper accumulator is WIDTH+1 bits so the add never overflows before the shift.
        sum  = prod_q[2*WIDTH:WIDTH] + {1'b0, (prod_q[0] ? mcand_q : '0)};
        step = {sum, prod_q[WIDTH-1:0]} >> 1;
`ifdef MUL_SIGNED_EN
        res  = neg_q ? -step[2*WIDTH-1:0] : step[2*WIDTH-1:0];
`else
        res  = step[2*WIDTH-1:0];
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d = mag_a;
                    prod_d  = {{(WIDTH+1){1'b0}}, mag_b};
                    cnt_d   = '0;
                    state_d = S_RUN;
`ifdef MUL_SIGNED_EN
                    neg_d   = instr & (a[WIDTH-1] ^ b[WIDTH-1]);
`endif
                end
            end
            S_RUN: begin
                prod_d = step;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH-1)) begin
                    lo_d    = res[WIDTH-1:0];
                    hi_d    = res[2*WIDTH-1:WIDTH];
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            done_q  <= 1'b0;
`ifdef MUL_SIGNED_EN
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            done_q  <= done_d;
`ifdef MUL_SIGNED_EN
            neg_q   <= neg_d;
`endif
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = done_q;
    assign lo   = lo_q;
    assign hi   = hi_q;

endmodule

// File: tb/tb_mul.sv
// Directed-vector bench for mul; expectations follow MUL_SIGNED_EN when it is defined.
module tb_mul;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic        instr;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] lo;
    logic [31:0] hi;

    int unsigned errors;
    int unsigned checks;
    logic [63:0] prev;

`ifdef MUL_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    mul #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .instr (instr),
        .start (start),
        .busy  (busy),
        .done  (done),
        .lo    (lo),
        .hi    (hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Capture on one edge, then expect exactly 32 busy edges with done only on the last.
    // poke > 0 raises start (with other operands) so that it is sampled at iteration edge poke.
    task automatic run_op(input string tag, input logic [31:0] opa, input logic [31:0] opb,
                          input logic ins, input logic [63:0] exp, input int poke);
        int bad;
        bad = 0;
        @(negedge clk);
        a = opa; b = opb; instr = ins; start = 1'b1;
        @(posedge clk); #1;
        check({tag, "_cap_busy"}, {63'd0, busy}, 64'd1);
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            a = ~opa; b = opb ^ 32'h5a5a_5a5a; instr = ~ins;
            start = (i == poke);
            if (i == poke) begin a = 32'd7; b = 32'd7; end
            @(posedge clk); #1;
            if (i < 32) begin
                if (busy !== 1'b1 || done !== 1'b0) bad++;
                if (i == 16) check({tag, "_hold"}, {hi, lo}, prev);
            end
        end
        check({tag, "_early"}, 64'(bad), 64'd0);
        check({tag, "_done"}, {63'd0, done}, 64'd1);
        check({tag, "_busy_end"}, {63'd0, busy}, 64'd0);
        check({tag, "_prod"}, {hi, lo}, exp);
        prev = exp;
        @(negedge clk);
        start = 1'b0;
        #1;
        check({tag, "_pulse"}, {63'd0, done}, 64'd1);
        @(posedge clk); #1;
        check({tag, "_pulse_end"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        errors = 0; checks = 0; prev = '0;
        rst_n = 1'b0; a = '0; b = '0; instr = 1'b0; start = 1'b0;
        #1;
        check("rst_outs", {60'd0, busy, done, |lo, |hi}, 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        run_op("neg2x2_s", 32'hFFFF_FFFE, 32'd2, 1'b1,
               SGN ? 64'hFFFF_FFFF_FFFF_FFFC : 64'h0000_0001_FFFF_FFFC, 0);
        run_op("neg2x2_u", 32'hFFFF_FFFE, 32'd2, 1'b0, 64'h0000_0001_FFFF_FFFC, 0);
        run_op("min_sq_s", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 0);
        run_op("ones_sq_u", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 0);
        run_op("ones_sq_s", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
               SGN ? 64'h0000_0000_0000_0001 : 64'hFFFF_FFFE_0000_0001, 0);
        run_op("min_x1_s", 32'h8000_0000, 32'd1, 1'b1,
               SGN ? 64'hFFFF_FFFF_8000_0000 : 64'h0000_0000_8000_0000, 0);
        run_op("7xm3_s", 32'd7, 32'hFFFF_FFFD, 1'b1,
               SGN ? 64'hFFFF_FFFF_FFFF_FFEB : 64'h0000_0006_FFFF_FFEB, 0);
        run_op("ffff_u", 32'h0000_FFFF, 32'h0001_0001, 1'b0, 64'h0000_0000_FFFF_FFFF, 0);
        run_op("zero_u", 32'd0, 32'h1234_5678, 1'b0, 64'd0, 0);
        run_op("restart", 32'd3, 32'd5, 1'b0, 64'd15, 10);
        run_op("start_at_done", 32'd6, 32'd9, 1'b0, 64'd54, 32);

        // Abort mid-operation: reset must clear outputs without a clock edge.
        @(negedge clk);
        a = 32'd100; b = 32'd100; instr = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        repeat (15) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_outs", {busy, done, 30'd0, hi, lo}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_nodone", {62'd0, busy, done}, 64'd0);
        #1 rst_n = 1'b1;
        prev = '0;
        run_op("after_rst", 32'd12, 32'd11, 1'b0, 64'd132, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul.md
MUL -- requirements
Module: mul

Interface
REQ-001 Parameter: WIDTH, default 32, operand width; lo and hi are each WIDTH bits; only 32 is required to be supported.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 a  input  32  multiplicand.
REQ-006 b  input  32  multiplier.
REQ-007 instr  input  1  operation select: 1 = signed (MULT), 0 = unsigned (MULTU).
REQ-008 start  input  1  request pulse; sampled on a rising clk edge.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse when a result is written.
REQ-011 lo  output  32  low half of the 64-bit product.
REQ-012 hi  output  32  high half of the 64-bit product.

Function
REQ-013 Product: {hi,lo} SHALL equal the full 64-bit product of a and b, with two's-complement interpretation when instr=1 and unsigned interpretation when instr=0.
REQ-014 Capture: on a rising edge with start=1 and busy=0, a, b and instr SHALL be latched and busy SHALL go high; input changes after capture SHALL NOT affect the result.
REQ-015 Algorithm: iterative shift-add on operand magnitudes, one partial-product bit per cycle, 32 iterations; for signed operations the sign is fixed at the end (negate if a[31]^b[31]).
REQ-016 Latency: with capture at edge N, iterations SHALL occur at edges N+1..N+32; at edge N+32 hi/lo SHALL be updated, done SHALL pulse high for exactly one cycle, and busy SHALL return low.
REQ-017 Start while busy: start SHALL be ignored while busy=1, including on the edge where done is asserted.
REQ-018 Back-to-back: start may be accepted on the first edge after busy returns low.
REQ-019 Hold: hi/lo SHALL keep the last result until the next completion; they SHALL NOT show intermediate values.
REQ-020 Signed corner cases: 0x80000000 operands SHALL be handled exactly, with no overflow of the internal magnitude path, which is 33 bits wide or equivalent.
REQ-021 Zero operands SHALL still take the full 32-cycle latency; there is no early termination.

Reset
REQ-022 While rst_n=0: busy=0, done=0, lo=0, hi=0, iteration counter=0, operand registers=0; assertion takes effect immediately, without waiting for clk.
REQ-023 Reset mid-operation SHALL abort the operation; no done pulse occurs for it, and a new start is accepted on the first edge after rst_n rises.

Configuration
REQ-024 Macro MUL_SIGNED_EN: when defined, instr selects signed or unsigned operation as in REQ-013.
REQ-025 When MUL_SIGNED_EN is undefined, instr SHALL be ignored and every operation SHALL be unsigned; the sign-correction logic SHALL be omitted.

Verification
REQ-026 a=0xFFFFFFFE (-2), b=2, instr=1, start -> after 32 cycles hi=0xFFFFFFFF, lo=0xFFFFFFFC, done pulses once.
REQ-027 Same operands, instr=0 -> hi=0x00000001, lo=0xFFFFFFFC; without MUL_SIGNED_EN the instr=1 case gives this same result.
REQ-028 a=b=0x80000000, instr=1 -> hi=0x40000000, lo=0x00000000; a=b=0xFFFFFFFF, instr=0 -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-029 start with a=3, b=5, then at cycle 10 pulse start again with a=7, b=7 -> second start ignored, result hi=0, lo=15, busy high for 32 cycles.
REQ-030 Drop rst_n at cycle 16 of an operation -> outputs 0 immediately, no done pulse; a new start after release gives the correct result.
